// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the updown_counter_n family.
package cnt_pkg;
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DN   = 1'b0;
  localparam logic CNT_WRAP = 1'b0;
  localparam logic CNT_SAT  = 1'b1;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/cnt_prescaler.sv
// Divides the enable stream: tick fires on every PRESCALE-th enabled cycle.
module cnt_prescaler
  import cnt_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int            PW   = clog2_min1(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;

  assign tick = en & (pcnt_q == LAST);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr)     pcnt_d = '0;
    else if (en) pcnt_d = tick ? '0 : pcnt_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pcnt_q <= '0;
    else        pcnt_q <= pcnt_d;
  end
endmodule

// File: rtl/updown_counter_n.sv
// Synchronous up/down counter with programmable modulus, load, wrap/saturate,
// terminal-count pulse and sticky wrap flag. CNT_PRESCALE_EN adds an en prescaler.
module updown_counter_n
  import cnt_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 2**WIDTH,
  parameter int RST_VAL  = 0,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             sat_mode,
  input  logic             clr_wrap,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrapped
);
  localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RSTV = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             wrapped_q, wrapped_d;
  logic             step;

`ifdef CNT_PRESCALE_EN
  cnt_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (en),
    .clr  (load),
    .tick (step)
  );
`else
  assign step = en;
`endif

  always_comb begin
    count_d   = count_q;
    tc_d      = 1'b0;
    wrapped_d = wrapped_q & ~clr_wrap;
    if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
    end else if (step) begin
      if (up_dn == CNT_UP) begin
        if (count_q == MAX) begin
          tc_d = 1'b1;
          if (sat_mode == CNT_WRAP) begin
            count_d   = '0;
            wrapped_d = 1'b1;
          end
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (sat_mode == CNT_WRAP) begin
            count_d   = MAX;
            wrapped_d = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= RSTV;
      tc_q      <= 1'b0;
      wrapped_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      tc_q      <= tc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign count   = count_q;
  assign tc      = tc_q;
  assign wrapped = wrapped_q;
endmodule
